// File: rtl/isa_cycle_engine_if.sv
// rtl/isa_cycle_engine_if.sv - request/response handshake and VGA pin bundle for isa_cycle_engine
// Master is the Zorro-side decoder plus the VGA chip; slave is the cycle engine.
interface isa_cycle_engine_if;
   logic        req_valid;
   logic        req_ready;
   logic        req_rd;
   logic        req_io;
   logic        req_sa0;
   logic        req_sa12;
   logic [15:0] req_wdata;
   logic        rsp_valid;
   logic [15:0] rsp_rdata;
   logic        rsp_timeout;
   logic        WAIT;
   logic [15:0] DG_IN;
   logic [15:0] DG_OUT;
   logic        DG_OE;
   logic        BALE;
   logic        MEMR;
   logic        MEMW;
   logic        IOR;
   logic        IOW;
   logic        SA0;
   logic        SA12;

   modport master (
      output req_valid, req_rd, req_io, req_sa0, req_sa12, req_wdata, WAIT, DG_IN,
      input  req_ready, rsp_valid, rsp_rdata, rsp_timeout,
      input  DG_OUT, DG_OE, BALE, MEMR, MEMW, IOR, IOW, SA0, SA12
   );

   modport slave (
      input  req_valid, req_rd, req_io, req_sa0, req_sa12, req_wdata, WAIT, DG_IN,
      output req_ready, rsp_valid, rsp_rdata, rsp_timeout,
      output DG_OUT, DG_OE, BALE, MEMR, MEMW, IOR, IOW, SA0, SA12
   );
endinterface

// File: rtl/isa_cycle_engine.sv
// rtl/isa_cycle_engine.sv - drives one ISA-style VGA bus cycle per accepted request
// Every pin is a register updated on the state transition that enters the phase it belongs to.
module isa_cycle_engine #(
   parameter int unsigned SETUP_CYC   = 2,
   parameter int unsigned STROBE_MIN  = 3,
   parameter int unsigned HOLD_CYC    = 2,
   parameter int unsigned TIMEOUT_CYC = 250
) (
   input  logic              mclk,
   input  logic              reset,
   isa_cycle_engine_if.slave bus
);
   typedef enum logic [2:0] {
      IDLE, ADDR, STROBE, WAITRDY, SAMPLE, HOLD, DONE
   } state_t;

   state_t      state_q;
   logic [15:0] cnt_q;
   logic        rd_q, io_q, timeout_q;
   logic        wait_s1_q, wait_s_q;
   logic [15:0] rdata_q;
   logic        req_ready_q, rsp_valid_q, rsp_timeout_q;
   logic [15:0] rsp_rdata_q, dg_out_q;
   logic        dg_oe_q, bale_q, memr_q, memw_q, ior_q, iow_q, sa0_q, sa12_q;

   always_ff @(posedge mclk) begin
      if (reset) begin
         wait_s1_q <= 1'b0;
         wait_s_q  <= 1'b0;
      end else begin
         wait_s1_q <= bus.WAIT;
         wait_s_q  <= wait_s1_q;
      end
   end

   always_ff @(posedge mclk) begin
      if (reset) begin
         state_q       <= IDLE;
         cnt_q         <= 16'd0;
         rd_q          <= 1'b0;
         io_q          <= 1'b0;
         timeout_q     <= 1'b0;
         rdata_q       <= 16'h0000;
         req_ready_q   <= 1'b1;
         rsp_valid_q   <= 1'b0;
         rsp_timeout_q <= 1'b0;
         rsp_rdata_q   <= 16'h0000;
         dg_out_q      <= 16'h0000;
         dg_oe_q       <= 1'b0;
         bale_q        <= 1'b1;
         memr_q        <= 1'b1;
         memw_q        <= 1'b1;
         ior_q         <= 1'b1;
         iow_q         <= 1'b1;
         sa0_q         <= 1'b1;
         sa12_q        <= 1'b1;
      end else begin
         rsp_valid_q <= 1'b0;
         unique case (state_q)
            IDLE: begin
               if (bus.req_valid) begin
                  rd_q        <= bus.req_rd;
                  io_q        <= bus.req_io;
                  sa0_q       <= bus.req_sa0;
                  sa12_q      <= bus.req_sa12;
                  bale_q      <= 1'b0;
                  req_ready_q <= 1'b0;
                  dg_oe_q     <= ~bus.req_rd;
                  dg_out_q    <= bus.req_rd ? 16'h0000 : bus.req_wdata;
                  cnt_q       <= 16'd0;
                  state_q     <= ADDR;
               end
            end
            ADDR: begin
               if (cnt_q == 16'(SETUP_CYC - 1)) begin
                  cnt_q   <= 16'd0;
                  state_q <= STROBE;
                  memr_q  <= ~(rd_q & ~io_q);
                  memw_q  <= ~(~rd_q & ~io_q);
                  ior_q   <= ~(rd_q & io_q);
                  iow_q   <= ~(~rd_q & io_q);
               end else begin
                  cnt_q <= cnt_q + 16'd1;
               end
            end
            STROBE: begin
               if (cnt_q == 16'(STROBE_MIN - 1)) begin
                  cnt_q   <= 16'd0;
                  // I/O cycles never stretch, whatever WAIT says.
                  state_q <= (io_q || wait_s_q) ? SAMPLE : WAITRDY;
               end else begin
                  cnt_q <= cnt_q + 16'd1;
               end
            end
            WAITRDY: begin
               if (wait_s_q) begin
                  cnt_q   <= 16'd0;
                  state_q <= SAMPLE;
               end else if (cnt_q == 16'(TIMEOUT_CYC - 1)) begin
                  timeout_q <= 1'b1;
                  cnt_q     <= 16'd0;
                  state_q   <= SAMPLE;
               end else begin
                  cnt_q <= cnt_q + 16'd1;
               end
            end
            SAMPLE: begin
               // Staged so rsp_rdata only changes together with rsp_valid.
               if (rd_q) begin
                  rdata_q <= timeout_q ? 16'hFFFF : bus.DG_IN;
               end
               memr_q  <= 1'b1;
               memw_q  <= 1'b1;
               ior_q   <= 1'b1;
               iow_q   <= 1'b1;
               cnt_q   <= 16'd0;
               state_q <= HOLD;
            end
            HOLD: begin
               if (cnt_q == 16'(HOLD_CYC - 1)) begin
                  cnt_q         <= 16'd0;
                  state_q       <= DONE;
                  bale_q        <= 1'b1;
                  sa0_q         <= 1'b1;
                  sa12_q        <= 1'b1;
                  dg_oe_q       <= 1'b0;
                  dg_out_q      <= 16'h0000;
                  rsp_valid_q   <= 1'b1;
                  rsp_timeout_q <= timeout_q;
                  if (rd_q) begin
                     rsp_rdata_q <= rdata_q;
                  end
               end else begin
                  cnt_q <= cnt_q + 16'd1;
               end
            end
            DONE: begin
               req_ready_q <= 1'b1;
               timeout_q   <= 1'b0;
               cnt_q       <= 16'd0;
               state_q     <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign bus.req_ready   = req_ready_q;
   assign bus.rsp_valid   = rsp_valid_q;
   assign bus.rsp_rdata   = rsp_rdata_q;
   assign bus.rsp_timeout = rsp_timeout_q;
   assign bus.DG_OUT      = dg_out_q;
   assign bus.DG_OE       = dg_oe_q;
   assign bus.BALE        = bale_q;
   assign bus.MEMR        = memr_q;
   assign bus.MEMW        = memw_q;
   assign bus.IOR         = ior_q;
   assign bus.IOW         = iow_q;
   assign bus.SA0         = sa0_q;
   assign bus.SA12        = sa12_q;
endmodule
